fu_cdb_unit: RTL and testbench

Integer functional unit at the consumer end of the reservation-station dispatch interface. It accepts one ready instruction per cycle from the RS (`RS_FU_*` bundle) and executes it: single-cycle ALU ops or an iterative multiply. Results are queued in a small result FIFO, and each one is broadcast as a `{ROBEN, value}` tag on one CDB port under a request/grant handshake. The CDB port feeds the ROB and the RS wakeup inputs (`CDB_ROBENx`/`CDB_ROBENx_VAL`).

---
 rtl/fu_cdb_unit.sv | 168 ++++++++++++++++
 tb/tb_fu_cdb_unit.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_cdb_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// fu_cdb_unit : integer FU (ALU + multi-cycle MUL) with CDB result FIFO
// Revision    : 1.0
// ---------------------------------------------------------------------------
module fu_cdb_unit #(
   parameter int RESULT_DEPTH = 4,
   parameter int MUL_LAT      = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  RS_FU_RS_ID,
   input  logic [4:0]  RS_FU_ROBEN,
   input  logic [11:0] RS_FU_opcode,
   input  logic [3:0]  RS_FU_ALUOP,
   input  logic [31:0] RS_FU_Val1,
   input  logic [31:0] RS_FU_Val2,
   input  logic [31:0] RS_FU_Immediate,
   input  logic        ROB_FLUSH_Flag,
   input  logic        CDB_Grant,
   output logic        FU_Is_Free,
   output logic        CDB_Req,
   output logic [4:0]  CDB_ROBEN,
   output logic [31:0] CDB_VAL
);

   localparam int c_PTR_W = $clog2(RESULT_DEPTH);
   localparam int c_CNT_W = $clog2(RESULT_DEPTH + 1);
   localparam int c_MC_W  = $clog2(MUL_LAT);
   localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(RESULT_DEPTH);
   localparam logic [c_MC_W-1:0]  c_MUL_INIT = c_MC_W'(MUL_LAT - 1);
   localparam logic [3:0]         c_OP_MUL   = 4'd11;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_t;

   state_t               state_q;
   logic [c_MC_W-1:0]    mul_cnt_q;
   logic [4:0]           mul_tag_q;
   logic [31:0]          mul_a_q;
   logic [31:0]          mul_b_q;
   logic [c_PTR_W-1:0]   rptr_q;
   logic [c_PTR_W-1:0]   wptr_q;
   logic [c_CNT_W-1:0]   count_q;
   logic [c_CNT_W-1:0]   count_d;
   logic [4:0]           tag_mem_q [RESULT_DEPTH];
   logic [31:0]          val_mem_q [RESULT_DEPTH];

   logic [31:0] w_a;
   logic [31:0] w_b;
   logic [31:0] w_alu;
   logic [31:0] w_mul_prod;
   logic        w_has_slot;
   logic        w_pop;
   logic        w_accept;
   logic        w_alu_push;
   logic        w_mul_start;
   logic        w_mul_push;
   logic        w_push;
   logic [4:0]  w_push_tag;
   logic [31:0] w_push_val;
   logic        w_unused_funct;

   assign w_unused_funct = ^RS_FU_opcode[5:0];

   assign w_a = RS_FU_Val1;
   assign w_b = (RS_FU_opcode[11:6] == 6'd0) ? RS_FU_Val2 : RS_FU_Immediate;

   always_comb begin
      w_alu = '0;
      case (RS_FU_ALUOP)
         4'd0:    w_alu = w_a + w_b;
         4'd1:    w_alu = w_a - w_b;
         4'd2:    w_alu = w_a & w_b;
         4'd3:    w_alu = w_a | w_b;
         4'd4:    w_alu = w_a ^ w_b;
         4'd5:    w_alu = ~(w_a | w_b);
         4'd6:    w_alu = w_a << w_b[4:0];
         4'd7:    w_alu = w_a >> w_b[4:0];
         4'd8:    w_alu = $signed(w_a) >>> w_b[4:0];
         4'd9:    w_alu = {31'd0, ($signed(w_a) < $signed(w_b))};
         4'd10:   w_alu = {31'd0, (w_a < w_b)};
         default: w_alu = '0;
      endcase
   end

   assign w_mul_prod  = mul_a_q * mul_b_q;
   assign w_has_slot  = (count_q < c_DEPTH);
   assign w_pop       = (count_q != '0) & CDB_Grant;
   assign FU_Is_Free  = rst & (state_q == S_IDLE) & w_has_slot;
   assign w_accept    = (RS_FU_RS_ID != 5'd0) & FU_Is_Free & ~ROB_FLUSH_Flag;
   assign w_alu_push  = w_accept & (RS_FU_ALUOP != c_OP_MUL);
   assign w_mul_start = w_accept & (RS_FU_ALUOP == c_OP_MUL);
   // A finished multiply may take the slot freed by a same-edge pop.
   assign w_mul_push  = (state_q == S_MUL) & (mul_cnt_q == '0) & (w_has_slot | w_pop)
                        & ~ROB_FLUSH_Flag;
   assign w_push      = w_alu_push | w_mul_push;
   assign w_push_tag  = (state_q == S_MUL) ? mul_tag_q  : RS_FU_ROBEN;
   assign w_push_val  = (state_q == S_MUL) ? w_mul_prod : w_alu;

   always_comb begin
      count_d = count_q;
      case ({w_push, w_pop})
         2'b10:   count_d = count_q + c_CNT_W'(1);
         2'b01:   count_d = count_q - c_CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         mul_cnt_q <= '0;
         mul_tag_q <= '0;
         mul_a_q   <= '0;
         mul_b_q   <= '0;
         rptr_q    <= '0;
         wptr_q    <= '0;
         count_q   <= '0;
      end else if (ROB_FLUSH_Flag) begin
         state_q   <= S_IDLE;
         mul_cnt_q <= '0;
         rptr_q    <= '0;
         wptr_q    <= '0;
         count_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (w_mul_start) begin
                  mul_tag_q <= RS_FU_ROBEN;
                  mul_a_q   <= w_a;
                  mul_b_q   <= w_b;
                  mul_cnt_q <= c_MUL_INIT;
                  state_q   <= S_MUL;
               end
            end
            S_MUL: begin
               if (mul_cnt_q != '0) begin
                  mul_cnt_q <= mul_cnt_q - c_MC_W'(1);
               end else if (w_mul_push) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
         if (w_push) wptr_q <= wptr_q + c_PTR_W'(1);
         if (w_pop)  rptr_q <= rptr_q + c_PTR_W'(1);
         count_q <= count_d;
      end
   end

   // Storage needs no reset: count_q gates every read.
   always_ff @(posedge clk) begin
      if (w_push) begin
         tag_mem_q[wptr_q] <= w_push_tag;
         val_mem_q[wptr_q] <= w_push_val;
      end
   end

   assign CDB_Req   = (count_q != '0);
   assign CDB_ROBEN = CDB_Req ? tag_mem_q[rptr_q] : 5'd0;
   assign CDB_VAL   = CDB_Req ? val_mem_q[rptr_q] : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_fu_cdb_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fu_cdb_unit : directed + random bench with queue-based reference model
// Revision       : 1.0
// ---------------------------------------------------------------------------
module tb_fu_cdb_unit;
   localparam int DEPTH = 4;
   localparam int MLAT  = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [4:0]  RS_FU_RS_ID = '0;
   logic [4:0]  RS_FU_ROBEN = '0;
   logic [11:0] RS_FU_opcode = '0;
   logic [3:0]  RS_FU_ALUOP = '0;
   logic [31:0] RS_FU_Val1 = '0;
   logic [31:0] RS_FU_Val2 = '0;
   logic [31:0] RS_FU_Immediate = '0;
   logic        ROB_FLUSH_Flag = 1'b0;
   logic        CDB_Grant = 1'b0;
   logic        FU_Is_Free;
   logic        CDB_Req;
   logic [4:0]  CDB_ROBEN;
   logic [31:0] CDB_VAL;

   fu_cdb_unit #(.RESULT_DEPTH(DEPTH), .MUL_LAT(MLAT)) dut (
      .clk(clk), .rst(rst),
      .RS_FU_RS_ID(RS_FU_RS_ID), .RS_FU_ROBEN(RS_FU_ROBEN),
      .RS_FU_opcode(RS_FU_opcode), .RS_FU_ALUOP(RS_FU_ALUOP),
      .RS_FU_Val1(RS_FU_Val1), .RS_FU_Val2(RS_FU_Val2),
      .RS_FU_Immediate(RS_FU_Immediate), .ROB_FLUSH_Flag(ROB_FLUSH_Flag),
      .CDB_Grant(CDB_Grant), .FU_Is_Free(FU_Is_Free), .CDB_Req(CDB_Req),
      .CDB_ROBEN(CDB_ROBEN), .CDB_VAL(CDB_VAL)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [4:0]  tag;
      logic [31:0] val;
   } ent_t;

   ent_t        mq[$];
   bit          m_busy = 1'b0;
   logic [4:0]  m_tag;
   logic [31:0] m_val;
   longint      cyc = 0;
   longint      m_due = 0;
   bit          mod_pop, mod_free, mod_push;
   ent_t        mod_e;
   logic [31:0] mod_b;

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a & b;
         4'd3:  return a | b;
         4'd4:  return a ^ b;
         4'd5:  return ~(a | b);
         4'd6:  return a << b[4:0];
         4'd7:  return a >> b[4:0];
         4'd8:  return $signed(a) >>> b[4:0];
         4'd9:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd10: return (a < b) ? 32'd1 : 32'd0;
         4'd11: return a * b;
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mq.delete();
         m_busy = 1'b0;
      end else begin
         mod_pop  = (mq.size() > 0) && CDB_Grant;
         mod_free = !m_busy && (mq.size() < DEPTH);
         mod_push = 1'b0;
         if (ROB_FLUSH_Flag) begin
            mq.delete();
            m_busy = 1'b0;
         end else begin
            if (m_busy) begin
               if (cyc >= m_due && (mq.size() < DEPTH || mod_pop)) begin
                  mod_e.tag = m_tag;
                  mod_e.val = m_val;
                  mod_push  = 1'b1;
                  m_busy    = 1'b0;
               end
            end else if (RS_FU_RS_ID != 5'd0 && mod_free) begin
               mod_b = (RS_FU_opcode[11:6] == 6'd0) ? RS_FU_Val2 : RS_FU_Immediate;
               if (RS_FU_ALUOP == 4'd11) begin
                  m_busy = 1'b1;
                  m_tag  = RS_FU_ROBEN;
                  m_val  = ref_alu(RS_FU_ALUOP, RS_FU_Val1, mod_b);
                  m_due  = cyc + MLAT;
               end else begin
                  mod_e.tag = RS_FU_ROBEN;
                  mod_e.val = ref_alu(RS_FU_ALUOP, RS_FU_Val1, mod_b);
                  mod_push  = 1'b1;
               end
            end
            if (mod_pop)  void'(mq.pop_front());
            if (mod_push) mq.push_back(mod_e);
         end
         cyc++;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (!rst) begin
         chk("rst_req",  32'(CDB_Req),    32'd0);
         chk("rst_tag",  32'(CDB_ROBEN),  32'd0);
         chk("rst_val",  CDB_VAL,         32'd0);
         chk("rst_free", 32'(FU_Is_Free), 32'd0);
      end else begin
         chk("req",  32'(CDB_Req),    32'(mq.size() > 0));
         chk("tag",  32'(CDB_ROBEN),  (mq.size() > 0) ? 32'(mq[0].tag) : 32'd0);
         chk("val",  CDB_VAL,         (mq.size() > 0) ? mq[0].val : 32'd0);
         chk("free", 32'(FU_Is_Free), 32'(!m_busy && mq.size() < DEPTH));
      end
   end

   // ---------------- stimulus ----------------
   task automatic drv(input logic [4:0] id, input logic [4:0] tag, input logic [5:0] maj,
                      input logic [3:0] op, input logic [31:0] v1, input logic [31:0] v2,
                      input logic [31:0] imm, input logic fl, input logic gr);
      RS_FU_RS_ID     = id;
      RS_FU_ROBEN     = tag;
      RS_FU_opcode    = {maj, 6'h20};
      RS_FU_ALUOP     = op;
      RS_FU_Val1      = v1;
      RS_FU_Val2      = v2;
      RS_FU_Immediate = imm;
      ROB_FLUSH_Flag  = fl;
      CDB_Grant       = gr;
   endtask

   task automatic idle(input logic gr);
      drv(5'd0, 5'd0, 6'd0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, gr);
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic fill4;
      for (int r = 1; r <= 4; r++) begin
         drv(5'd1, 5'(r), 6'd0, 4'd0, 32'(r), 32'd100, 32'd0, 1'b0, 1'b0);
         step();
      end
   endtask

   int exp_t[3];

   initial begin
      // reset / idle
      repeat (3) @(posedge clk);
      #1;
      chk("lit_rst_req", 32'(CDB_Req), 32'd0);
      chk("lit_rst_free", 32'(FU_Is_Free), 32'd0);
      rst = 1'b1;
      #1;
      chk("lit_rel_free", 32'(FU_Is_Free), 32'd1);
      chk("lit_rel_req", 32'(CDB_Req), 32'd0);

      // ALU with register and immediate operand
      drv(5'd1, 5'd3, 6'd0, 4'd1, 32'd10, 32'd15, 32'd0, 1'b0, 1'b1);
      step();
      chk("lit_sub_tag", 32'(CDB_ROBEN), 32'd3);
      chk("lit_sub_val", CDB_VAL, 32'hFFFFFFFB);
      drv(5'd1, 5'd4, 6'h08, 4'd8, 32'h80000000, 32'd0, 32'd4, 1'b0, 1'b1);
      step();
      chk("lit_sra_val", CDB_VAL, 32'hF8000000);
      idle(1'b1);
      step();
      chk("lit_drained", 32'(CDB_Req), 32'd0);

      // MUL latency, dispatches during MUL ignored
      drv(5'd1, 5'd7, 6'd0, 4'd11, 32'h10000, 32'h10001, 32'd0, 1'b0, 1'b0);
      step();
      for (int i = 1; i < MLAT; i++) begin
         chk("lit_mul_free", 32'(FU_Is_Free), 32'd0);
         chk("lit_mul_req", 32'(CDB_Req), 32'd0);
         drv(5'd2, 5'd20, 6'd0, 4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0);
         step();
      end
      chk("lit_mul_free_last", 32'(FU_Is_Free), 32'd0);
      idle(1'b0);
      step();
      chk("lit_mul_tag", 32'(CDB_ROBEN), 32'd7);
      chk("lit_mul_val", CDB_VAL, 32'h00010000);
      chk("lit_mul_free_after", 32'(FU_Is_Free), 32'd1);
      idle(1'b1);
      step();
      chk("lit_mul_drained", 32'(CDB_Req), 32'd0);

      // FIFO full, drop, drain in order, pointer wrap
      for (int rep = 0; rep < 3; rep++) begin
         fill4();
         chk("lit_full_free", 32'(FU_Is_Free), 32'd0);
         drv(5'd1, 5'd5, 6'd0, 4'd0, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0);
         step();
         chk("lit_full_head", 32'(CDB_ROBEN), 32'd1);
         idle(1'b1);
         for (int r = 1; r <= 4; r++) begin
            chk("lit_drain_tag", 32'(CDB_ROBEN), 32'(r));
            step();
         end
         chk("lit_drain_empty", 32'(CDB_Req), 32'd0);
      end

      // simultaneous push/pop around full
      fill4();
      drv(5'd1, 5'd9, 6'd0, 4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1);
      step();
      chk("lit_pp_free", 32'(FU_Is_Free), 32'd1);
      chk("lit_pp_head", 32'(CDB_ROBEN), 32'd2);
      drv(5'd1, 5'd10, 6'd0, 4'd0, 32'd5, 32'd6, 32'd0, 1'b0, 1'b1);
      step();
      chk("lit_pp_free2", 32'(FU_Is_Free), 32'd1);
      exp_t = '{3, 4, 10};
      idle(1'b1);
      for (int k = 0; k < 3; k++) begin
         chk("lit_pp_tag", 32'(CDB_ROBEN), 32'(exp_t[k]));
         if (k == 2) chk("lit_pp_val", CDB_VAL, 32'd11);
         step();
      end
      chk("lit_pp_empty", 32'(CDB_Req), 32'd0);

      // flush with queued results and MUL in flight
      drv(5'd1, 5'd11, 6'd0, 4'd2, 32'hF0, 32'h3C, 32'd0, 1'b0, 1'b0);
      step();
      drv(5'd1, 5'd12, 6'd0, 4'd3, 32'hF0, 32'h0F, 32'd0, 1'b0, 1'b0);
      step();
      drv(5'd1, 5'd13, 6'd0, 4'd11, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0);
      step();
      chk("lit_fl_busy", 32'(FU_Is_Free), 32'd0);
      drv(5'd1, 5'd14, 6'd0, 4'd0, 32'd1, 32'd1, 32'd0, 1'b1, 1'b0);
      step();
      chk("lit_fl_req", 32'(CDB_Req), 32'd0);
      chk("lit_fl_free", 32'(FU_Is_Free), 32'd1);
      idle(1'b1);
      repeat (MLAT + 2) begin
         step();
         chk("lit_fl_no_mul", 32'(CDB_Req), 32'd0);
      end
      drv(5'd1, 5'd15, 6'd0, 4'd0, 32'd1, 32'd2, 32'd0, 1'b1, 1'b1);
      step();
      chk("lit_fl_drop", 32'(CDB_Req), 32'd0);

      // reset in the middle of a MUL
      drv(5'd1, 5'd21, 6'd0, 4'd11, 32'd7, 32'd9, 32'd0, 1'b0, 1'b0);
      step();
      idle(1'b0);
      step();
      #2 rst = 1'b0;
      #1;
      chk("lit_mr_free", 32'(FU_Is_Free), 32'd0);
      chk("lit_mr_req", 32'(CDB_Req), 32'd0);
      step();
      rst = 1'b1;
      #1;
      chk("lit_mr_rel_free", 32'(FU_Is_Free), 32'd1);
      repeat (MLAT + 1) begin
         step();
         chk("lit_mr_no_mul", 32'(CDB_Req), 32'd0);
      end

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [4:0]  rid;
         logic [3:0]  rop;
         logic [31:0] ra, rb, ri;
         rid = ($urandom_range(0, 9) < 7) ? 5'($urandom_range(1, 31)) : 5'd0;
         rop = ($urandom_range(0, 5) == 0) ? 4'd11 : 4'($urandom_range(0, 15));
         ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         ri  = $urandom;
         drv(rid, 5'($urandom_range(0, 31)),
             ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(1, 63)),
             rop, ra, rb, ri, ($urandom_range(0, 39) == 0),
             ($urandom_range(0, 9) < 6));
         if ($urandom_range(0, 599) == 0) begin
            rst = 1'b0;
            step();
            rst = 1'b1;
         end else begin
            step();
         end
      end

      idle(1'b0);
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
